score_digit_scheduler: RTL and testbench

- Drives one shared number-sprite instance (24x24 1-bit glyphs, ROM indexed by digit) so that it renders a NUM_DIGITS-wide decimal score.
- Converts a binary score to BCD with a sequential double-dabble FSM into a shadow register, then swaps it into the display register only during vertical blanking, so there is no tearing.
- On every pixel it selects which digit the sprite draws and at what x position.
- It sits between the video timing generator and the sprite instance.

---
 rtl/score_pkg.sv | 15 +
 rtl/score_digit_scheduler_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 rtl/score_digit_scheduler.sv | 133 +++++++++++++
 tb/tb_score_digit_scheduler.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared types for the score digit scheduler.
//   bcd_t        : one BCD nibble
//   bcd_vec_t    : a default-width vector of BCD nibbles
//   conv_state_t : binary-to-BCD converter states
package score_pkg;

  localparam int unsigned NUM_DIGITS_DEFAULT = 4;
  localparam int unsigned SLACK_DEFAULT      = 4;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [NUM_DIGITS_DEFAULT-1:0] bcd_vec_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

endpackage

// File: rtl/score_digit_scheduler_if.sv
// Score update handshake between the game logic and the digit scheduler.
//   score_in       : binary score
//   score_valid_in : one-cycle pulse capturing score_in
//   busy_out       : BCD conversion in progress
// master = score producer, slave = scheduler.
interface score_digit_scheduler_if #(
  parameter int unsigned SCORE_W = 14
);
  logic [SCORE_W-1:0] score_in;
  logic               score_valid_in;
  logic               busy_out;

  modport master (output score_in, output score_valid_in, input busy_out);
  modport slave  (input score_in, input score_valid_in, output busy_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending slot.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : pulse, captures i_value (queued as pending when not idle)
//   i_value        : binary value, clamped to 10^NUM_DIGITS-1
//   o_busy         : high while shifting (SCORE_W cycles)
//   o_done         : high for the single DONE cycle; o_bcd is valid then
//   o_bcd          : BCD result, most-significant nibble at the top
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [SCORE_W-1:0]      i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  localparam int unsigned BcdW     = 4 * NUM_DIGITS;
  localparam int unsigned CntW     = $clog2(SCORE_W + 1);
  localparam logic [63:0] MaxScore = 64'(10 ** NUM_DIGITS) - 64'd1;

  conv_state_t        r_state;
  logic [SCORE_W-1:0] r_bin;
  logic [BcdW-1:0]    r_bcd;
  logic [CntW-1:0]    r_cnt;
  logic               r_pend;
  logic [SCORE_W-1:0] r_pend_val;
  logic               r_busy;
  logic               r_done;
  logic [BcdW-1:0]    w_adj;

  function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
    if (64'(v) > MaxScore) return MaxScore[SCORE_W-1:0];
    return v;
  endfunction

  function automatic logic [BcdW-1:0] add3(input logic [BcdW-1:0] b);
    logic [BcdW-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj  = add3(r_bcd);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A fresh start beats a stale pending value (last write wins).
          if (i_start || r_pend) begin
            r_bin   <= i_start ? clamp(i_value) : clamp(r_pend_val);
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[BcdW-2:0], r_bin[SCORE_W-1]};
          r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntW'(SCORE_W - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
          if (i_start) begin
            r_pend     <= 1'b1;
            r_pend_val <= i_value;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (i_start) begin
            r_pend     <= 1'b1;
            r_pend_val <= i_value;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_digit_scheduler.sv
// Multiplexes one number sprite across NUM_DIGITS decimal digits of a score.
//   pixel_clk_in, rst_n_in : pixel clock, synchronous active-low reset
//   score_bus              : score handshake (score_in, score_valid_in, busy_out)
//   x_in                   : left edge of the most-significant digit
//   hcount_in, vcount_in   : raw video counters
//   blank_lz_in            : suppress leading zeros
//   hcount_out, vcount_out : counters delayed one cycle for the sprite
//   digit_x_out            : sprite x position, aligned with hcount_out
//   digit_num_out          : sprite digit, aligned with hcount_out
//   digit_en_out           : draw gate, SLACK cycles behind digit_num_out
module score_digit_scheduler
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned GAP        = 8,
  parameter int unsigned SLACK      = SLACK_DEFAULT,
  parameter int unsigned V_SWAP     = 720
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  score_digit_scheduler_if.slave    score_bus,
  input  logic [10:0]               x_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      blank_lz_in,
  output logic [10:0]               hcount_out,
  output logic [9:0]                vcount_out,
  output logic [10:0]               digit_x_out,
  output logic [3:0]                digit_num_out,
  output logic                      digit_en_out
);

  localparam int unsigned BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned Pitch = WIDTH + GAP;

  logic [BcdW-1:0]       r_shadow;
  logic                  r_shadow_ready;
  logic [BcdW-1:0]       r_display;
  logic [10:0]           r_hcount;
  logic [9:0]            r_vcount;
  logic [10:0]           r_digit_x;
  logic [3:0]            r_digit_num;
  logic [SLACK:0]        r_en_pipe;

  logic                  w_done;
  logic [BcdW-1:0]       w_bcd;
  logic                  w_commit;
  logic [10:0]           w_digit_x;
  logic [3:0]            w_digit_num;
  logic                  w_digit_en;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_zero;
  logic [11:0]           w_start;
  logic [11:0]           w_thresh;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCORE_W    (SCORE_W)
  ) u_conv (
    .i_clk   (pixel_clk_in),
    .i_rst_n (rst_n_in),
    .i_start (score_bus.score_valid_in),
    .i_value (score_bus.score_in),
    .o_busy  (score_bus.busy_out),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  assign w_commit = (vcount_in == 10'(V_SWAP)) && (hcount_in == 11'd0) && r_shadow_ready;

  // Digit k takes over once the previous digit plus the sprite's compare slack has passed,
  // so the ROM address leads the sprite's delayed in_sprite window.
  always_comb begin
    w_digit_x   = x_in;
    w_digit_num = r_display[BcdW-1 -: 4];
    w_zero      = 1'b1;
    w_blank     = '0;
    w_start     = '0;
    w_thresh    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_zero     = w_zero & (r_display[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      w_blank[k] = blank_lz_in & w_zero & (k != NUM_DIGITS - 1);
    end
    w_digit_en = !w_blank[0];
    for (int k = 1; k < NUM_DIGITS; k++) begin
      w_start  = {1'b0, x_in} + 12'(k * Pitch);
      w_thresh = {1'b0, x_in} + 12'((k - 1) * Pitch + WIDTH + SLACK);
      // Positions past 2047 never match rather than wrapping.
      if (!w_start[11] && !w_thresh[11] && ({1'b0, hcount_in} >= w_thresh)) begin
        w_digit_x   = w_start[10:0];
        w_digit_num = r_display[4*(NUM_DIGITS-1-k) +: 4];
        w_digit_en  = !w_blank[k];
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      r_shadow       <= '0;
      r_shadow_ready <= 1'b0;
      r_display      <= '0;
      r_hcount       <= '0;
      r_vcount       <= '0;
      r_digit_x      <= '0;
      r_digit_num    <= '0;
      r_en_pipe      <= '0;
    end else begin
      r_hcount    <= hcount_in;
      r_vcount    <= vcount_in;
      r_digit_x   <= w_digit_x;
      r_digit_num <= w_digit_num;
      r_en_pipe   <= {r_en_pipe[SLACK-1:0], w_digit_en};
      if (w_commit) begin
        r_display      <= r_shadow;
        r_shadow_ready <= 1'b0;
      end
      // A simultaneous DONE write wins the ready flag; the commit used the old shadow.
      if (w_done) begin
        r_shadow       <= w_bcd;
        r_shadow_ready <= 1'b1;
      end
    end
  end

  assign hcount_out    = r_hcount;
  assign vcount_out    = r_vcount;
  assign digit_x_out   = r_digit_x;
  assign digit_num_out = r_digit_num;
  assign digit_en_out  = r_en_pipe[SLACK];

endmodule

// File: tb/tb_score_digit_scheduler.sv
module tb_score_digit_scheduler;

  localparam int N  = 4;
  localparam int SW = 14;
  localparam int W  = 24;
  localparam int G  = 8;
  localparam int SL = 4;
  localparam int VS = 720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x_in = '0;
  logic [10:0] h_in = '0;
  logic [9:0]  v_in = '0;
  logic        blz = 1'b0;
  logic [10:0] h_out;
  logic [9:0]  v_out;
  logic [10:0] dx;
  logic [3:0]  dnum;
  logic        den;

  int checks = 0;
  int failures = 0;

  score_digit_scheduler_if #(.SCORE_W(SW)) bus ();

  score_digit_scheduler #(
    .NUM_DIGITS (N),
    .SCORE_W    (SW),
    .WIDTH      (W),
    .GAP        (G),
    .SLACK      (SL),
    .V_SWAP     (VS)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_n_in      (rst_n),
    .score_bus     (bus),
    .x_in          (x_in),
    .hcount_in     (h_in),
    .vcount_in     (v_in),
    .blank_lz_in   (blz),
    .hcount_out    (h_out),
    .vcount_out    (v_out),
    .digit_x_out   (dx),
    .digit_num_out (dnum),
    .digit_en_out  (den)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int h;
    int ex;
    int enum_;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the clamped score.
  function automatic int sat(input int s);
    return (s > 10 ** N - 1) ? 10 ** N - 1 : s;
  endfunction

  function automatic int digit_of(input int s, input int k);
    return (s / (10 ** (N - 1 - k))) % 10;
  endfunction

  function automatic bit blank_of(input int s, input int k, input bit b);
    return b && (k < N - 1) && (s < 10 ** (N - 1 - k));
  endfunction

  function automatic int exp_k(input int x, input int h);
    int k;
    k = 0;
    for (int j = 1; j < N; j++) begin
      if ((x + j * (W + G) < 2048) && (x + (j - 1) * (W + G) + W + SL < 2048) &&
          (h >= x + (j - 1) * (W + G) + W + SL))
        k = j;
    end
    return k;
  endfunction

  task automatic pulse(input int v);
    bus.score_in = SW'(v);
    bus.score_valid_in = 1'b1;
    tick();
    bus.score_valid_in = 1'b0;
  endtask

  task automatic wait_quiet();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 200) begin
      tick();
      n++;
      quiet = bus.busy_out ? 0 : quiet + 1;
    end
    if (quiet < 4) chk("wait_quiet_timeout", 0, 1);
  endtask

  task automatic commit();
    v_in = 10'(VS);
    h_in = '0;
    tick();
    v_in = '0;
  endtask

  task automatic load(input int v);
    pulse(v);
    wait_quiet();
    commit();
  endtask

  task automatic check_digit(input string tag, input int x, input int h, input int score,
                             input bit b);
    int k;
    int s;
    x_in = 11'(x);
    h_in = 11'(h);
    blz = b;
    repeat (SL + 1) tick();
    k = exp_k(x, h);
    s = sat(score);
    chk($sformatf("%s_x", tag), 32'(dx), 32'(x + k * (W + G)));
    chk($sformatf("%s_num", tag), 32'(dnum), 32'(digit_of(s, k)));
    chk($sformatf("%s_en", tag), 32'(den), 32'(!blank_of(s, k, b)));
  endtask

  initial begin
    int cur;
    int n;
    int s;
    int x;
    bit b;

    tbl[0]  = '{1234, 50, 100, 1};
    tbl[1]  = '{1234, 127, 100, 1};
    tbl[2]  = '{1234, 128, 132, 2};
    tbl[3]  = '{1234, 159, 132, 2};
    tbl[4]  = '{1234, 160, 164, 3};
    tbl[5]  = '{1234, 191, 164, 3};
    tbl[6]  = '{1234, 192, 196, 4};
    tbl[7]  = '{1234, 600, 196, 4};
    tbl[8]  = '{12000, 0, 100, 9};
    tbl[9]  = '{12000, 140, 132, 9};
    tbl[10] = '{12000, 170, 164, 9};
    tbl[11] = '{12000, 300, 196, 9};

    bus.score_in = '0;
    bus.score_valid_in = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy_out), 0);
    chk("rst_num", 32'(dnum), 0);
    chk("rst_en", 32'(den), 0);
    chk("rst_x", 32'(dx), 0);
    chk("rst_hout", 32'(h_out), 0);
    chk("rst_vout", 32'(v_out), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven digit selection
    cur = -1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].score != cur) begin
        load(tbl[i].score);
        cur = tbl[i].score;
      end
      x_in = 11'd100;
      h_in = 11'(tbl[i].h);
      tick();
      chk($sformatf("tbl%0d_hout", i), 32'(h_out), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_x", i), 32'(dx), 32'(tbl[i].ex));
      chk($sformatf("tbl%0d_num", i), 32'(dnum), 32'(tbl[i].enum_));
    end

    // Busy lasts exactly SCORE_W cycles
    pulse(1234);
    n = 0;
    while (bus.busy_out && n < 100) begin
      n++;
      tick();
    end
    chk("busy_len", 32'(n), 32'(SW));
    wait_quiet();
    commit();

    // Tearing: conversion mid-frame stays hidden until the swap cycle
    v_in = 10'd300;
    pulse(5678);
    wait_quiet();
    x_in = 11'd100;
    h_in = 11'd50;
    tick();
    chk("tear_hold_msd", 32'(dnum), 1);
    h_in = 11'd250;
    tick();
    chk("tear_hold_lsd", 32'(dnum), 4);
    v_in = 10'(VS);
    h_in = 11'd0;
    tick();
    chk("tear_swap_cycle", 32'(dnum), 1);
    v_in = 10'(VS + 1);
    tick();
    chk("tear_after_swap", 32'(dnum), 5);
    v_in = '0;
    tick();

    // Back-to-back: second pulse lands in pending, last write wins
    pulse(55);
    repeat (4) tick();
    pulse(777);
    wait_quiet();
    commit();
    for (int k = 0; k < N; k++) check_digit($sformatf("b2b%0d", k), 100, 110 + 32 * k, 777, 1'b0);

    // Leading-zero blanking
    load(7);
    for (int k = 0; k < N; k++) check_digit($sformatf("lz7_%0d", k), 100, 110 + 32 * k, 7, 1'b1);
    // Enable trails the digit by exactly SLACK cycles
    h_in = 11'd170;
    repeat (SL + 1) tick();
    h_in = 11'd200;
    tick();
    chk("lz_edge_num", 32'(dnum), 7);
    chk("lz_edge_en0", 32'(den), 0);
    repeat (SL - 1) tick();
    chk("lz_edge_en_late", 32'(den), 0);
    tick();
    chk("lz_edge_en_on", 32'(den), 1);
    load(0);
    for (int k = 0; k < N; k++) check_digit($sformatf("lz0_%0d", k), 100, 110 + 32 * k, 0, 1'b1);
    for (int k = 0; k < N; k++) check_digit($sformatf("nolz_%0d", k), 100, 110 + 32 * k, 0, 1'b0);

    // Reset mid-conversion aborts it and clears the display
    load(4321);
    pulse(9999);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("midrst_busy", 32'(bus.busy_out), 0);
    chk("midrst_num", 32'(dnum), 0);
    chk("midrst_en", 32'(den), 0);
    rst_n = 1'b1;
    repeat (30) tick();
    commit();
    for (int k = 0; k < N; k++) check_digit($sformatf("postrst%0d", k), 100, 110 + 32 * k, 0, 1'b0);

    // Randomized scores, positions and blanking against the decimal model
    for (int it = 0; it < 20; it++) begin
      s = int'($urandom_range(0, 16383));
      b = 1'($urandom_range(0, 1));
      x = (it % 4 == 0) ? int'($urandom_range(1950, 2047)) : int'($urandom_range(0, 1800));
      load(s);
      for (int j = 0; j < 5; j++) begin
        check_digit($sformatf("rnd%0d_%0d", it, j), x, int'($urandom_range(0, 2047)), s, b);
      end
      check_digit($sformatf("rnd%0d_edge", it), x, (x + W + SL > 2047) ? 2047 : x + W + SL, s, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
